// File: rtl/hour_counter_bcd.sv
// hour_counter_bcd: BCD hour-of-day counter, switchable 12/24-hour, with load, conversion and wrap.
// Define HOUR_COUNTER_DOWN_EN to make dec count backwards; otherwise dec is ignored.
module hour_counter_bcd #(
    parameter logic [3:0] RESET_TENS = 4'd1,
    parameter logic [3:0] RESET_ONES = 4'd2,
    parameter logic       RESET_PM   = 1'b0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       inc,
    input  logic       dec,
    input  logic       mode24,
    input  logic       load,
    input  logic [3:0] load_tens,
    input  logic [3:0] load_ones,
    input  logic       load_pm,
    output logic [3:0] tens,
    output logic [3:0] ones,
    output logic       pm,
    output logic       wrap,
    output logic       load_err
);
    logic [3:0] tens_q, tens_d, ones_q, ones_d;
    logic       pm_q, pm_d, wrap_q, wrap_d, load_err_q, load_err_d, mode_q, mode_d;
    logic       up, dn, ld_ok;
    logic [4:0] cur_val, h24, nxt_h;
    logic [7:0] ld_val;

`ifdef HOUR_COUNTER_DOWN_EN
    assign up = inc & ~dec;
    assign dn = dec & ~inc;
`else
    assign up = inc;
    assign dn = dec & 1'b0;
`endif

    // Encode a 0..23 hour as BCD in the requested display mode.
    function automatic logic [7:0] enc(input logic [4:0] h, input logic m);
        logic [4:0] n;
        logic [3:0] t;
        n = m ? h : (h == 5'd0 ? 5'd12 : (h > 5'd12 ? h - 5'd12 : h));
        t = n >= 5'd20 ? 4'd2 : (n >= 5'd10 ? 4'd1 : 4'd0);
        return {t, 4'(n - 5'(t) * 5'd10)};
    endfunction

    assign cur_val = 5'(tens_q) * 5'd10 + 5'(ones_q);
    // The stored digits are in the format of the registered mode; normalise to 0..23.
    assign h24 = mode_q ? cur_val :
                 (cur_val == 5'd12 ? (pm_q ? 5'd12 : 5'd0) : (pm_q ? cur_val + 5'd12 : cur_val));
    assign nxt_h = up ? (h24 == 5'd23 ? 5'd0 : h24 + 5'd1) :
                   dn ? (h24 == 5'd0 ? 5'd23 : h24 - 5'd1) : h24;
    assign ld_val = 8'(load_tens) * 8'd10 + 8'(load_ones);
    assign ld_ok = load_ones <= 4'd9 &&
                   (mode24 ? ld_val <= 8'd23 : (ld_val >= 8'd1 && ld_val <= 8'd12));

    always_comb begin
        tens_d     = tens_q;
        ones_d     = ones_q;
        pm_d       = pm_q;
        wrap_d     = 1'b0;
        load_err_d = 1'b0;
        mode_d     = mode24;
        if (load) begin
            if (ld_ok) begin
                tens_d = load_tens;
                ones_d = load_ones;
                pm_d   = mode24 ? ld_val >= 8'd12 : load_pm;
            end else begin
                load_err_d = 1'b1;
                mode_d     = mode_q;
            end
        end else if (mode24 != mode_q) begin
            {tens_d, ones_d} = enc(h24, mode24);
            pm_d             = h24 >= 5'd12;
        end else if (up || dn) begin
            {tens_d, ones_d} = enc(nxt_h, mode_q);
            pm_d             = nxt_h >= 5'd12;
            wrap_d           = (up && h24 == 5'd23) || (dn && h24 == 5'd0);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            tens_q     <= RESET_TENS;
            ones_q     <= RESET_ONES;
            pm_q       <= RESET_PM;
            wrap_q     <= 1'b0;
            load_err_q <= 1'b0;
            mode_q     <= mode24;
        end else begin
            tens_q     <= tens_d;
            ones_q     <= ones_d;
            pm_q       <= pm_d;
            wrap_q     <= wrap_d;
            load_err_q <= load_err_d;
            mode_q     <= mode_d;
        end
    end

    assign tens     = tens_q;
    assign ones     = ones_q;
    assign pm       = pm_q;
    assign wrap     = wrap_q;
    assign load_err = load_err_q;
endmodule

// File: tb/tb_hour_counter_bcd.sv
// tb_hour_counter_bcd: directed checks of counting, conversion, loads, wrap and reset priority.
module tb_hour_counter_bcd;
    logic       clk = 1'b0;
    logic       reset, inc, dec, mode24, load, load_pm;
    logic [3:0] load_tens, load_ones, tens, ones;
    logic       pm, wrap, load_err;
    logic [10:0] cur;
    int n_run = 0, n_fail = 0;

    always #5 clk = ~clk;

    hour_counter_bcd dut (
        .clk(clk), .reset(reset), .inc(inc), .dec(dec), .mode24(mode24), .load(load),
        .load_tens(load_tens), .load_ones(load_ones), .load_pm(load_pm),
        .tens(tens), .ones(ones), .pm(pm), .wrap(wrap), .load_err(load_err)
    );

    assign cur = {tens, ones, pm, wrap, load_err};

    function automatic logic [10:0] st(input int t, input int o, input int p, input int w, input int e);
        return {4'(t), 4'(o), 1'(p), 1'(w), 1'(e)};
    endfunction

    task automatic chk(input string tag, input logic [10:0] got, input logic [10:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got{t,o,pm,wrap,err}=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic ld(input int t, input int o, input int p);
        load = 1'b1;
        load_tens = 4'(t);
        load_ones = 4'(o);
        load_pm = 1'(p);
        tick;
        load = 1'b0;
    endtask

    initial begin
        reset = 1'b1; inc = 1'b0; dec = 1'b0; mode24 = 1'b0; load = 1'b0;
        load_pm = 1'b0; load_tens = 4'd0; load_ones = 4'd0;
        tick; tick;
        reset = 1'b0;
        chk("rst", cur, st(1, 2, 0, 0, 0));
        inc = 1'b1;
        for (int i = 1; i <= 24; i++) begin
            int h, n;
            h = i % 24;
            n = (h == 0) ? 12 : (h > 12 ? h - 12 : h);
            tick;
            chk($sformatf("inc12_%0d", i), cur, st(n / 10, n % 10, h >= 12, i == 24, 0));
        end
        inc = 1'b0;
        tick; chk("wrap_1cyc", cur, st(1, 2, 0, 0, 0));
        ld(1, 1, 1); chk("ld_11pm", cur, st(1, 1, 1, 0, 0));
        mode24 = 1'b1; tick; chk("cv_23", cur, st(2, 3, 1, 0, 0));
        inc = 1'b1; tick; inc = 1'b0; chk("wrap_24", cur, st(0, 0, 0, 1, 0));
        mode24 = 1'b0; tick; chk("cv_12am", cur, st(1, 2, 0, 0, 0));
        mode24 = 1'b1; inc = 1'b1; tick; inc = 1'b0; chk("cv_ign_inc", cur, st(0, 0, 0, 0, 0));
        ld(1, 3, 0); chk("ld_13_24", cur, st(1, 3, 1, 0, 0));
        mode24 = 1'b0; tick; chk("cv_1pm", cur, st(0, 1, 1, 0, 0));
        ld(1, 2, 1); chk("ld_12pm", cur, st(1, 2, 1, 0, 0));
        mode24 = 1'b1; tick; chk("cv_12pm_12", cur, st(1, 2, 1, 0, 0));
        mode24 = 1'b0; tick; chk("cv_12_12pm", cur, st(1, 2, 1, 0, 0));
        ld(0, 5, 1);
        mode24 = 1'b1; tick; chk("cv_5pm_17", cur, st(1, 7, 1, 0, 0));
        mode24 = 1'b0; tick; chk("cv_17_5pm", cur, st(0, 5, 1, 0, 0));
        ld(1, 3, 0); chk("ld_13_12_err", cur, st(0, 5, 1, 0, 1));
        tick; chk("err_1cyc", cur, st(0, 5, 1, 0, 0));
        ld(0, 0, 0); chk("ld_00_12_err", cur, st(0, 5, 1, 0, 1));
        ld(0, 10, 0); chk("ld_ones_err", cur, st(0, 5, 1, 0, 1));
        mode24 = 1'b1; tick; chk("cv_17", cur, st(1, 7, 1, 0, 0));
        ld(2, 4, 0); chk("ld_24_err", cur, st(1, 7, 1, 0, 1));
        ld(0, 0, 1); chk("ld_00_pm_ign", cur, st(0, 0, 0, 0, 0));
        mode24 = 1'b0; tick; chk("cv_00_12am", cur, st(1, 2, 0, 0, 0));
        ld(0, 7, 0); chk("ld_07am", cur, st(0, 7, 0, 0, 0));
        inc = 1'b1; dec = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            tick;
`ifdef HOUR_COUNTER_DOWN_EN
            chk($sformatf("incdec_%0d", i), cur, st(0, 7, 0, 0, 0));
`else
            chk($sformatf("incdec_%0d", i), cur, st((7 + i) / 10, (7 + i) % 10, (7 + i) >= 12, 0, 0));
`endif
        end
        inc = 1'b0; dec = 1'b0;
`ifdef HOUR_COUNTER_DOWN_EN
        ld(1, 2, 0);
        dec = 1'b1;
        tick; chk("dec_wrap12", cur, st(1, 1, 1, 1, 0));
        tick; chk("dec_10pm", cur, st(1, 0, 1, 0, 0));
        dec = 1'b0;
        ld(1, 2, 1);
        dec = 1'b1; tick; dec = 1'b0; chk("dec_12pm_11am", cur, st(1, 1, 0, 0, 0));
        mode24 = 1'b1; tick; chk("cv_11", cur, st(1, 1, 0, 0, 0));
        ld(0, 0, 0);
        dec = 1'b1; tick; dec = 1'b0; chk("dec_wrap24", cur, st(2, 3, 1, 1, 0));
        mode24 = 1'b0; tick; chk("cv_11pm", cur, st(1, 1, 1, 0, 0));
`else
        ld(0, 7, 0);
        dec = 1'b1; tick; tick; dec = 1'b0;
        chk("dec_ign", cur, st(0, 7, 0, 0, 0));
`endif
        ld(0, 5, 1); chk("ld_5pm", cur, st(0, 5, 1, 0, 0));
        reset = 1'b1; load = 1'b1; load_tens = 4'd1; load_ones = 4'd3; inc = 1'b1;
        tick;
        reset = 1'b0; load = 1'b0; inc = 1'b0;
        chk("rst_pri", cur, st(1, 2, 0, 0, 0));
        ld(1, 1, 1);
        mode24 = 1'b1; reset = 1'b1; tick; reset = 1'b0;
        chk("rst_cv", cur, st(1, 2, 0, 0, 0));
        tick; chk("rst_hist", cur, st(1, 2, 0, 0, 0));
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule
